// File: rtl/dma_pkg.sv
// Shared types and constants for the 8237A-compatible DMA timing controller.
// States, transfer-mode / transfer-type encodings and bus command bit positions.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_SI = 3'd0,
        ST_S0 = 3'd1,
        ST_S1 = 3'd2,
        ST_S2 = 3'd3,
        ST_S3 = 3'd4,
        ST_SW = 3'd5,
        ST_S4 = 3'd6,
        ST_SC = 3'd7
    } dma_state_e;

    // Mode register bits [7:6]
    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    // Mode register bits [3:2]
    localparam logic [1:0] XFER_VERIFY  = 2'b00;
    localparam logic [1:0] XFER_WRITE   = 2'b01;
    localparam logic [1:0] XFER_READ    = 2'b10;
    localparam logic [1:0] XFER_ILLEGAL = 2'b11;

    // Bit positions inside the active-low command vector
    localparam int CMD_MEMR = 0;
    localparam int CMD_MEMW = 1;
    localparam int CMD_IOR  = 2;
    localparam int CMD_IOW  = 3;
    localparam int CMD_W    = 4;

endpackage

// File: rtl/dma_cmd_gen.sv
// Bus command decoder: turns the current bus state, transfer type and
// extended-write / compressed-timing options into the four active-low commands.
module dma_cmd_gen
    import dma_pkg::*;
(
    input  dma_state_e       state_i,
    input  logic [1:0]       xfer_type_i,
    input  logic             ext_write_i,
    input  logic             compress_i,
    output logic [CMD_W-1:0] cmd_n_o
);

    logic             readPhase;
    logic             writePhase;
    logic [CMD_W-1:0] cmdActive;

    // Read command spans S2 through the wait states; write command starts in S3 unless pulled into S2.
    always_comb begin
        readPhase  = (state_i == ST_S2) || (state_i == ST_S3) || (state_i == ST_SW);
        writePhase = (state_i == ST_S3) || (state_i == ST_SW) ||
                     ((state_i == ST_S2) && (ext_write_i || compress_i));
        cmdActive  = '0;
        case (xfer_type_i)
            XFER_WRITE: begin
                cmdActive[CMD_IOR]  = readPhase;
                cmdActive[CMD_MEMW] = writePhase;
            end
            XFER_READ: begin
                cmdActive[CMD_MEMR] = readPhase;
                cmdActive[CMD_IOW]  = writePhase;
            end
            default: begin
                cmdActive = '0;
            end
        endcase
        cmd_n_o = ~cmdActive;
    end

endmodule

// File: rtl/dma_timing_ctrl.sv
// Per-service bus timing FSM for the 8237A-compatible DMA: HRQ/HLDA handshake,
// S0..S4 bus cycle, DACK, step pulses, TC/EOP and service-done reporting.
// Optional feature macro: DMA_COMPRESSED_TIMING_EN (compressed timing, S3 skipped).
module dma_timing_ctrl
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    input  logic [CH_W-1:0]   req_ch_i,
    input  logic [NUM_CH-1:0] dreq_act_i,
    input  logic [7:0]        mode_i,
    input  logic              cmd_compress_i,
    input  logic              cmd_extw_i,
    input  logic [15:0]       cur_count_i,
    input  logic              addr_carry_i,
    input  logic              hlda_i,
    input  logic              ready_i,
    input  logic              eop_in_n_i,
    output logic              hrq_o,
    output logic [NUM_CH-1:0] dack_act_o,
    output logic              aen_o,
    output logic              adstb_o,
    output logic              memr_n_o,
    output logic              memw_n_o,
    output logic              ior_n_o,
    output logic              iow_n_o,
    output logic              eop_out_n_o,
    output logic              addr_step_o,
    output logic              count_step_o,
    output logic              svc_done_o
);

    dma_state_e       state_q, state_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [7:0]       mode_q, mode_d;
    logic             eopSeen_q, eopSeen_d;

    logic [1:0]       xferMode;
    logic [1:0]       xferType;
    logic             chReq;
    logic             termCount;
    logic             serviceEnd;
    logic             compressEn;
    logic             dackOn;
    logic [CMD_W-1:0] cmdN;
    logic             unusedBits;

    assign xferMode  = mode_q[7:6];
    assign xferType  = mode_q[3:2];
    assign chReq     = dreq_act_i[chan_q];
    assign termCount = (cur_count_i == 16'd0);

    // Without compressed timing the CMD_COMPRESS bit has no effect at all.
`ifdef DMA_COMPRESSED_TIMING_EN
    assign compressEn = cmd_compress_i;
    assign unusedBits = ^{mode_q[5:4], mode_q[1:0]};
`else
    assign compressEn = 1'b0;
    assign unusedBits = ^{mode_q[5:4], mode_q[1:0], cmd_compress_i};
`endif

    // Conditions that end the service once the current S4 completes.
    assign serviceEnd = termCount || eopSeen_q || !eop_in_n_i || !hlda_i ||
                        (xferMode == MODE_SINGLE) ||
                        ((xferMode == MODE_DEMAND) && !chReq);

    // State register plus the channel/mode latched for the whole service.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_SI;
            chan_q    <= '0;
            mode_q    <= '0;
            eopSeen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            mode_q    <= mode_d;
            eopSeen_q <= eopSeen_d;
        end
    end

    // Next-state logic; external EOP is remembered from S2 until the closing S4.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        mode_d    = mode_q;
        eopSeen_d = 1'b0;
        case (state_q)
            ST_SI: begin
                if (req_valid_i) begin
                    chan_d  = req_ch_i;
                    mode_d  = mode_i;
                    state_d = ST_S0;
                end
            end
            ST_S0: begin
                if (hlda_i) begin
                    state_d = (xferMode == MODE_CASCADE) ? ST_SC : ST_S1;
                end
            end
            ST_SC: begin
                if (!chReq) begin
                    state_d = ST_SI;
                end
            end
            ST_S1: begin
                state_d = ST_S2;
            end
            ST_S2: begin
                eopSeen_d = eopSeen_q || !eop_in_n_i;
                if (compressEn) begin
                    state_d = ready_i ? ST_S4 : ST_SW;
                end else begin
                    state_d = ST_S3;
                end
            end
            ST_S3: begin
                eopSeen_d = eopSeen_q || !eop_in_n_i;
                state_d   = ready_i ? ST_S4 : ST_SW;
            end
            ST_SW: begin
                eopSeen_d = eopSeen_q || !eop_in_n_i;
                if (ready_i) begin
                    state_d = ST_S4;
                end
            end
            ST_S4: begin
                if (serviceEnd) begin
                    state_d = ST_SI;
                end else if (compressEn && !addr_carry_i) begin
                    state_d = ST_S2;
                end else begin
                    state_d = ST_S1;
                end
            end
            default: begin
                state_d = ST_SI;
            end
        endcase
    end

    // Output decode from the current state; SVC_DONE and TC also look at live inputs.
    always_comb begin
        hrq_o        = (state_q != ST_SI);
        dackOn       = (state_q != ST_SI) && (state_q != ST_S0);
        aen_o        = dackOn && (state_q != ST_SC);
        adstb_o      = (state_q == ST_S1);
        addr_step_o  = (state_q == ST_S4);
        count_step_o = (state_q == ST_S4);
        eop_out_n_o  = !((state_q == ST_S4) && termCount);
        svc_done_o   = ((state_q == ST_S4) && serviceEnd) ||
                       ((state_q == ST_SC) && !chReq);
        dack_act_o   = dackOn ? ({{(NUM_CH-1){1'b0}}, 1'b1} << chan_q) : '0;
    end

    dma_cmd_gen u_cmd_gen (
        .state_i     (state_q),
        .xfer_type_i (xferType),
        .ext_write_i (cmd_extw_i),
        .compress_i  (compressEn),
        .cmd_n_o     (cmdN)
    );

    assign memr_n_o = cmdN[CMD_MEMR];
    assign memw_n_o = cmdN[CMD_MEMW];
    assign ior_n_o  = cmdN[CMD_IOR];
    assign iow_n_o  = cmdN[CMD_IOW];

endmodule
